axi_sram_slave: RTL and testbench

- AXI4 burst slave fronting the on-chip SRAM window; consumes write and read bursts from the DMA and MCU masters through the interconnect.
- Single-ported behavioural word array. One transaction in flight at a time.
- Accepts INCR bursts of 1–256 beats and returns B/R responses that carry the captured ID.

---
 rtl/axi_sram_slave_if.sv | 58 +++++
 rtl/axi_sram_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 burst channels between the interconnect and the SRAM window slave.
// Signals keep their AXI names; master/slave modports set the direction.
interface axi_sram_slave_if #(
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64
);
   logic [AXI_ID_WIDTH-1:0]   awid;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [7:0]                awlen;
   logic                      awvalid;
   logic                      awready;
   logic [AXI_DATA_WIDTH-1:0] wdata;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [AXI_ID_WIDTH-1:0]   bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [AXI_ID_WIDTH-1:0]   arid;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [7:0]                arlen;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_ID_WIDTH-1:0]   rid;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rlast;
   logic                      rready;

   modport master (
      output awid, awaddr, awlen, awvalid,
      input  awready,
      output wdata, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arvalid,
      input  arready,
      input  rid, rdata, rresp, rvalid, rlast,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awvalid,
      output awready,
      input  wdata, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arvalid,
      output arready,
      output rid, rdata, rresp, rvalid, rlast,
      input  rready
   );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR burst slave over a single-ported SRAM word array.
// One transaction in flight; round-robin arbitration between AW and AR.
module axi_sram_slave #(
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int DEPTH_WORDS    = 1024
) (
   input logic clk,
   input logic rst_n,
   axi_sram_slave_if.slave bus
);
   localparam int BPW = AXI_DATA_WIDTH / 8;
   localparam int SH  = $clog2(BPW);
   localparam int IW  = $clog2(DEPTH_WORDS);
   localparam int AW  = AXI_ADDR_WIDTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WDATA = 2'd1;
   localparam logic [1:0] WRESP = 2'd2;
   localparam logic [1:0] RDATA = 2'd3;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH_WORDS - 1);

   logic [1:0]              state;
   logic                    prio_rd;
   logic [AXI_ID_WIDTH-1:0] id_q;
   logic [AW-1:0]           idx_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_q;
   logic                    dec_q;
   logic                    slv_q;

   logic [AXI_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic          aw_go;
   logic          ar_go;
   logic [AW-1:0] aw_off;
   logic [AW-1:0] ar_off;
   logic [AW-1:0] aw_idx;
   logic [AW-1:0] ar_idx;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_nxt;
   logic          aw_dec;
   logic          ar_dec;
   logic          last_beat;
   logic          wlast_bad;
   logic          unused_ok;

   assign aw_off = bus.awaddr - BASE_ADDR;
   assign ar_off = bus.araddr - BASE_ADDR;
   assign aw_idx = aw_off >> SH;
   assign ar_idx = ar_off >> SH;

   // Window check made once at the address handshake
   assign aw_dec = (bus.awaddr < BASE_ADDR) ||
                   ({1'b0, aw_idx} +
                    {{(AW-7){1'b0}}, bus.awlen} > LAST_IDX);
   assign ar_dec = (bus.araddr < BASE_ADDR) ||
                   ({1'b0, ar_idx} +
                    {{(AW-7){1'b0}}, bus.arlen} > LAST_IDX);

   assign wr_idx = idx_q + AW'(beat_q);
   assign rd_nxt = idx_q + AW'(beat_q) + AW'(1);

   assign last_beat = (beat_q == len_q);
   assign wlast_bad = (bus.wlast != last_beat);

   assign aw_go = rst_n && (state == IDLE) && bus.awvalid &&
                  (!prio_rd || !bus.arvalid);
   assign ar_go = rst_n && (state == IDLE) && bus.arvalid &&
                  (prio_rd || !bus.awvalid);

   assign bus.awready = aw_go;
   assign bus.arready = ar_go;
   assign bus.wready  = (state == WDATA);

   assign unused_ok = ^{wr_idx[AW-1:IW], rd_nxt[AW-1:IW]};

   always_ff @(posedge clk) begin
      if (state == WDATA && bus.wvalid && !dec_q)
         mem[wr_idx[IW-1:0]] <= bus.wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prio_rd    <= 1'b0;
         id_q       <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         dec_q      <= 1'b0;
         slv_q      <= 1'b0;
         bus.bvalid <= 1'b0;
         bus.bid    <= '0;
         bus.bresp  <= OKAY;
         bus.rvalid <= 1'b0;
         bus.rlast  <= 1'b0;
         bus.rid    <= '0;
         bus.rdata  <= '0;
         bus.rresp  <= OKAY;
      end else begin
         unique case (1'b1)
            (state == IDLE): begin
               if (aw_go) begin
                  state   <= WDATA;
                  prio_rd <= !prio_rd;
                  id_q    <= bus.awid;
                  idx_q   <= aw_idx;
                  len_q   <= bus.awlen;
                  beat_q  <= '0;
                  dec_q   <= aw_dec;
                  slv_q   <= 1'b0;
               end else if (ar_go) begin
                  state      <= RDATA;
                  prio_rd    <= !prio_rd;
                  id_q       <= bus.arid;
                  idx_q      <= ar_idx;
                  len_q      <= bus.arlen;
                  beat_q     <= '0;
                  dec_q      <= ar_dec;
                  bus.rvalid <= 1'b1;
                  bus.rid    <= bus.arid;
                  bus.rresp  <= ar_dec ? DECERR : OKAY;
                  bus.rlast  <= (bus.arlen == 8'd0);
                  bus.rdata  <= ar_dec ? '0 :
                                mem[ar_idx[IW-1:0]];
               end
            end
            (state == WDATA): begin
               if (bus.wvalid) begin
                  if (last_beat) begin
                     state      <= WRESP;
                     bus.bvalid <= 1'b1;
                     bus.bid    <= id_q;
                     bus.bresp  <= dec_q ? DECERR :
                                   (slv_q || wlast_bad) ? SLVERR :
                                   OKAY;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     slv_q  <= slv_q | wlast_bad;
                  end
               end
            end
            (state == WRESP): begin
               if (bus.bready) begin
                  bus.bvalid <= 1'b0;
                  state      <= IDLE;
               end
            end
            (state == RDATA): begin
               if (bus.rready) begin
                  if (last_beat) begin
                     bus.rvalid <= 1'b0;
                     bus.rlast  <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     beat_q    <= beat_q + 8'd1;
                     bus.rlast <= ((beat_q + 8'd1) == len_q);
                     bus.rdata <= dec_q ? '0 :
                                  mem[rd_nxt[IW-1:0]];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed table, corner sequences and
// random bursts checked against a word-array reference model.
module tb_axi_sram_slave;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 1024;
   localparam int          BPW   = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [63:0] mem_m [DEPTH];

   axi_sram_slave_if bus ();

   axi_sram_slave dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [3:0]  id;
      logic [31:0] addr;
      int          len;
      int          last_at;
      logic [63:0] dbase;
      logic [1:0]  exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic bit is_dec(input logic [31:0] a, input int len);
      longint ua;
      longint ub;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, BASE});
      if (ua < ub) return 1'b1;
      return ((ua - ub) / BPW + len) > (DEPTH - 1);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'({32'b0, a}) - longint'({32'b0, BASE})) / BPW);
   endfunction

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_awready"}, bus.awready, 0);
      chk({tag, "_arready"}, bus.arready, 0);
      chk({tag, "_wready"},  bus.wready,  0);
      chk({tag, "_bvalid"},  bus.bvalid,  0);
      chk({tag, "_rvalid"},  bus.rvalid,  0);
      chk({tag, "_rlast"},   bus.rlast,   0);
      chk({tag, "_bid"},     bus.bid,     0);
      chk({tag, "_rid"},     bus.rid,     0);
      chk({tag, "_rdata"},   bus.rdata,   0);
      chk({tag, "_bresp"},   bus.bresp,   0);
      chk({tag, "_rresp"},   bus.rresp,   0);
   endtask

   task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                     input int len, input int last_at, input int bwait,
                     input logic [63:0] dbase, input bit gaps,
                     output logic [1:0] resp);
      bit          dec;
      int          idx;
      int          la;
      int          n;
      logic [63:0] d;
      logic [1:0]  er;
      dec = is_dec(addr, len);
      idx = dec ? 0 : widx(addr);
      la  = (last_at == -1) ? len : last_at;
      er  = dec ? 2'b11 : (la != len) ? 2'b10 : 2'b00;
      bus.awid = id; bus.awaddr = addr;
      bus.awlen = 8'(len); bus.awvalid = 1'b1;
      #1;
      n = 0;
      while (bus.awready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("awready", bus.awready, 1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.wvalid = 1'b0;
            @(posedge clk); #1;
         end
         d = dbase + 64'(i) * 64'h0000_0001_0000_0001;
         bus.wdata = d; bus.wlast = (i == la); bus.wvalid = 1'b1;
         #1;
         chk("wready", bus.wready, 1);
         chk("bvalid_early", bus.bvalid, 0);
         @(posedge clk); #1;
         if (!dec) mem_m[idx + i] = d;
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      chk("bvalid", bus.bvalid, 1);
      chk("bid", bus.bid, id);
      chk("bresp", bus.bresp, er);
      resp = bus.bresp;
      for (int c = 0; c < bwait; c++) begin
         @(posedge clk); #1;
         chk("bvalid_hold", bus.bvalid, 1);
         chk("bresp_hold", bus.bresp, er);
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      chk("bvalid_fall", bus.bvalid, 0);
   endtask

   // mode 0: rready high, 1: random, 2: 1-0-0-1 then high
   task automatic rd(input logic [3:0] id, input logic [31:0] addr,
                     input int len, input int mode,
                     output logic [1:0] resp);
      bit          dec;
      int          idx;
      int          beat;
      int          n;
      bit          rr;
      bit          stalled;
      logic [63:0] hd;
      logic        hl;
      dec = is_dec(addr, len);
      idx = dec ? 0 : widx(addr);
      resp = 2'bxx;
      bus.arid = id; bus.araddr = addr;
      bus.arlen = 8'(len); bus.arvalid = 1'b1;
      #1;
      n = 0;
      while (bus.arready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("arready", bus.arready, 1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      chk("rvalid_rise", bus.rvalid, 1);
      beat = 0; n = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
      while (beat <= len && n < 3000) begin
         case (mode)
            0:       rr = 1'b1;
            1:       rr = 1'($urandom_range(0, 1));
            default: rr = !(n == 1 || n == 2);
         endcase
         bus.rready = rr;
         #1;
         chk("rvalid", bus.rvalid, 1);
         if (stalled) begin
            chk("rdata_hold", bus.rdata, hd);
            chk("rlast_hold", bus.rlast, hl);
         end
         if (rr) begin
            chk("rdata", bus.rdata, dec ? 64'd0 : mem_m[idx + beat]);
            chk("rresp", bus.rresp, dec ? 2'b11 : 2'b00);
            chk("rid", bus.rid, id);
            chk("rlast", bus.rlast, beat == len);
            resp = bus.rresp;
            beat++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            hd = bus.rdata;
            hl = bus.rlast;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.rready = 1'b0;
      chk("rvalid_fall", bus.rvalid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [$];
      logic [1:0]  r;
      logic [31:0] a;
      int          ln;
      int          la;
      int          ix;

      checks = 0; errors = 0;
      rst_n = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      #1;
      chk_reset_outs("rst0");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int b = 0; b < 4; b++)
         wr(4'd1, BASE + 32'(b * 256 * BPW), 255, -1, 0,
            64'hA5A5_0000_0000_0000 + 64'(b) * 64'h1_0000_0000_0000, 1'b0, r);

      tbl.push_back('{1'b0, 4'd3, 32'h1000_0040, 1, -1,
                      64'hD0A00000_5A5A0000, 2'b00});
      tbl.push_back('{1'b1, 4'd5, 32'h1000_0040, 1, -1, 64'd0, 2'b00});
      tbl.push_back('{1'b0, 4'd6, 32'h0FFF_FFF8, 0, -1,
                      64'hDEAD_0000_0000_0000, 2'b11});
      tbl.push_back('{1'b1, 4'd7, 32'h1000_1FF0, 3, -1, 64'd0, 2'b11});
      tbl.push_back('{1'b1, 4'd8, 32'h1000_1FE0, 3, -1, 64'd0, 2'b00});
      tbl.push_back('{1'b0, 4'd9, 32'h1000_1FF8, 0, -1,
                      64'h1111_2222_3333_4444, 2'b00});
      tbl.push_back('{1'b0, 4'd10, 32'h1000_1FF8, 1, -1,
                      64'hBAD0_0000_0000_0000, 2'b11});
      tbl.push_back('{1'b0, 4'd11, 32'h1000_0400, 3, 1,
                      64'h0C0C_0000_0000_0000, 2'b10});
      tbl.push_back('{1'b1, 4'd11, 32'h1000_0400, 3, -1, 64'd0, 2'b00});
      tbl.push_back('{1'b0, 4'd12, 32'h1000_0480, 0, -2,
                      64'h0D0D_0000_0000_0000, 2'b10});
      tbl.push_back('{1'b0, 4'd13, 32'h0FFF_FFF0, 1, 0,
                      64'hBAD1_0000_0000_0000, 2'b11});
      tbl.push_back('{1'b0, 4'd14, 32'h1000_0105, 0, -1,
                      64'h0123_4567_89AB_CDEF, 2'b00});
      tbl.push_back('{1'b1, 4'd15, 32'h1000_0100, 0, -1, 64'd0, 2'b00});
      tbl.push_back('{1'b1, 4'd2, 32'hFFFF_FFF8, 0, -1, 64'd0, 2'b11});
      tbl.push_back('{1'b1, 4'd4, 32'h1000_1FF8, 0, -1, 64'd0, 2'b00});

      foreach (tbl[k]) begin
         if (tbl[k].rd)
            rd(tbl[k].id, tbl[k].addr, tbl[k].len, 0, r);
         else
            wr(tbl[k].id, tbl[k].addr, tbl[k].len, tbl[k].last_at, 0,
               tbl[k].dbase, 1'b0, r);
         chk($sformatf("tbl%0d_resp", k), r, tbl[k].exp);
      end

      wr(4'd3, 32'h1000_0600, 2, -1, 5, 64'h5555_0000_0000_0000, 1'b0, r);
      rd(4'd4, 32'h1000_0600, 3, 2, r);

      wr(4'd7, BASE + 32'h200, 7, -1, 0, 64'h7777_0000_0000_0000, 1'b0, r);
      bus.awid = 4'd6; bus.awaddr = BASE + 32'h200;
      bus.awlen = 8'd7; bus.awvalid = 1'b1;
      #1;
      chk("mid_awready", bus.awready, 1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wdata = 64'hBEEF_0000_0000_0000 + 64'(i);
         bus.wlast = 1'b0; bus.wvalid = 1'b1;
         @(posedge clk); #1;
         mem_m[64 + i] = 64'hBEEF_0000_0000_0000 + 64'(i);
      end
      bus.wvalid = 1'b0;
      rst_n = 1'b0;
      bus.awvalid = 1'b1; bus.arvalid = 1'b1; bus.wvalid = 1'b1;
      #1;
      chk_reset_outs("rst_mid");
      @(posedge clk); #1;
      chk_reset_outs("rst_mid2");
      bus.awvalid = 1'b0; bus.arvalid = 1'b0; bus.wvalid = 1'b0;
      rst_n = 1'b1;

      bus.arid = 4'd2; bus.araddr = BASE + 32'h300; bus.arlen = 8'd1;
      bus.awid = 4'd1; bus.awaddr = BASE + 32'h380; bus.awlen = 8'd1;
      bus.arvalid = 1'b1; bus.awvalid = 1'b1;
      #1;
      chk("arb1_awready", bus.awready, 1);
      chk("arb1_arready", bus.arready, 0);
      wr(4'd1, BASE + 32'h380, 1, -1, 0, 64'hA1A1_0000_0000_0000, 1'b0, r);
      rd(4'd2, BASE + 32'h300, 1, 0, r);
      wr(4'd3, BASE + 32'h390, 0, -1, 0, 64'hA2A2_0000_0000_0000, 1'b0, r);
      bus.arid = 4'd4; bus.araddr = BASE + 32'h380; bus.arlen = 8'd1;
      bus.awid = 4'd5; bus.awaddr = BASE + 32'h3A0; bus.awlen = 8'd0;
      bus.arvalid = 1'b1; bus.awvalid = 1'b1;
      #1;
      chk("arb2_arready", bus.arready, 1);
      chk("arb2_awready", bus.awready, 0);
      rd(4'd4, BASE + 32'h380, 1, 0, r);
      wr(4'd5, BASE + 32'h3A0, 0, -1, 0, 64'hA3A3_0000_0000_0000, 1'b0, r);

      rd(4'd9, BASE + 32'h200, 7, 0, r);

      for (int t = 0; t < 60; t++) begin
         ln = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0) ln = $urandom_range(0, 255);
         ix = $urandom_range(0, DEPTH - 1);
         a  = BASE + 32'(ix * BPW) + 32'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = $urandom;
         la = -1;
         if ($urandom_range(0, 9) == 0) la = $urandom_range(0, ln);
         if ($urandom_range(0, 19) == 0) la = -2;
         if ($urandom_range(0, 1) == 1)
            rd(4'($urandom), a, ln, 1, r);
         else
            wr(4'($urandom), a, ln, la, $urandom_range(0, 3),
               {$urandom, $urandom}, 1'b1, r);
      end

      for (int b = 0; b < 4; b++)
         rd(4'd0, BASE + 32'(b * 256 * BPW), 255, 0, r);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
